ecc_decode_control: RTL and testbench



---
 rtl/ecc_pkg.sv | 17 +
 rtl/ecc_decode_control_if.sv | 29 ++
 rtl/ecc_word_unpacker.sv | 50 +++++
 rtl/ecc_decode_control.sv | 93 +++++++++
 tb/tb_ecc_decode_control.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ecc_pkg.sv
// Shared constants and FSM state encoding for the LDPC encode/decode controllers.
package ecc_pkg;
   localparam int N          = 9216;
   localparam int K          = 8192;
   localparam int M          = N - K;
   localparam int W          = 32;
   localparam int CODE_WORDS = N / W;
   localparam int DATA_WORDS = K / W;
   localparam int CNT_W      = 9;

   typedef enum logic [1:0] {
      COLLECT,
      START,
      WAIT,
      OUTPUT
   } ecc_state_e;
endpackage

// File: rtl/ecc_decode_control_if.sv
// Flash-side, decoder-side and host-side signals of the decode controller.
interface ecc_decode_control_if;
   import ecc_pkg::*;

   logic [W-1:0] data_in;
   logic         ecc_decode_req;
   logic         wr_en;
   logic         code_rdy;
   logic [N-1:0] codeword;
   logic         dec_start;
   logic         dec_done;
   logic         dec_fail;
   logic [K-1:0] dec_data;
   logic         rd_en;
   logic [W-1:0] data_out;
   logic         data_out_vld;
   logic         dec_err;
   logic         read_over;

   modport master (
      output data_in, ecc_decode_req, wr_en, dec_done, dec_fail, dec_data, rd_en,
      input  code_rdy, codeword, dec_start, data_out, data_out_vld, dec_err, read_over
   );

   modport slave (
      input  data_in, ecc_decode_req, wr_en, dec_done, dec_fail, dec_data, rd_en,
      output code_rdy, codeword, dec_start, data_out, data_out_vld, dec_err, read_over
   );
endinterface

// File: rtl/ecc_word_unpacker.sv
// Parallel-load buffer that shifts out one word per request, low word first,
// with a word counter and a registered last-word pulse.
module ecc_word_unpacker
   import ecc_pkg::*;
#(
   parameter int DW = K,
   parameter int WW = W,
   parameter int CW = CNT_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          shift,
   output logic [WW-1:0] word_out,
   output logic          word_vld,
   output logic          last,
   output logic          last_word
);

   logic [DW-1:0] shreg;
   logic [CW-1:0] cnt;

   assign last_word = (cnt == CW'(DW / WW - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg    <= '0;
         cnt      <= '0;
         word_out <= '0;
         word_vld <= 1'b0;
         last     <= 1'b0;
      end else begin
         word_vld <= 1'b0;
         last     <= 1'b0;
         if (load) begin
            shreg <= load_data;
            cnt   <= '0;
         end else if (shift) begin
            word_out <= shreg[WW-1:0];
            shreg    <= shreg >> WW;
            word_vld <= 1'b1;
            last     <= last_word;
            // wrap so the next codeword starts counting from zero
            cnt      <= last_word ? '0 : cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ecc_decode_control.sv
// Collects a flash codeword, hands it to the LDPC decoder and streams the
// corrected data words back to the host.
module ecc_decode_control
   import ecc_pkg::*;
(
   input logic                  clk,
   input logic                  rst_n,
   ecc_decode_control_if.slave  bus
);

   ecc_state_e       state;
   logic [CNT_W-1:0] col_cnt;
   logic [N-1:0]     codeword_q;
   logic             code_rdy_q;
   logic             dec_start_q;
   logic             dec_err_q;
   logic             accept;
   logic             load;
   logic             shift;
   logic             last_word;

   assign accept = (state == COLLECT) && bus.ecc_decode_req && bus.wr_en;
   assign load   = (state == WAIT) && bus.dec_done;
   assign shift  = (state == OUTPUT) && bus.rd_en;

   assign bus.code_rdy  = code_rdy_q;
   assign bus.codeword  = codeword_q;
   assign bus.dec_start = dec_start_q;
   assign bus.dec_err   = dec_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= COLLECT;
         col_cnt     <= '0;
         codeword_q  <= '0;
         code_rdy_q  <= 1'b1;
         dec_start_q <= 1'b0;
         dec_err_q   <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  codeword_q <= {bus.data_in, codeword_q[N-1:W]};
                  col_cnt    <= col_cnt + CNT_W'(1);
                  if (col_cnt == CNT_W'(CODE_WORDS - 1)) begin
                     state       <= START;
                     code_rdy_q  <= 1'b0;
                     dec_start_q <= 1'b1;
                     // failure flag belongs to the codeword being started
                     dec_err_q   <= 1'b0;
                  end
               end
            end
            START: begin
               dec_start_q <= 1'b0;
               state       <= WAIT;
            end
            WAIT: begin
               if (bus.dec_done) begin
                  dec_err_q <= bus.dec_fail;
                  state     <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (shift && last_word) begin
                  state      <= COLLECT;
                  code_rdy_q <= 1'b1;
                  codeword_q <= '0;
                  col_cnt    <= '0;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

   ecc_word_unpacker #(
      .DW (K),
      .WW (W),
      .CW (CNT_W)
   ) u_unpacker (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (bus.dec_data),
      .shift     (shift),
      .word_out  (bus.data_out),
      .word_vld  (bus.data_out_vld),
      .last      (bus.read_over),
      .last_word (last_word)
   );

endmodule

// File: tb/tb_ecc_decode_control.sv
// Directed bench for ecc_decode_control: collect, decode handshake, readout,
// flow-control pauses, decode failure, stray strobes and mid-read reset.
module tb_ecc_decode_control;
   import ecc_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   ds_cnt = 0;

   always #5 clk = ~clk;

   ecc_decode_control_if bus ();

   ecc_decode_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always @(negedge clk) if (rst_n && bus.dec_start) ds_cnt++;

   initial begin
      #1ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int n, input logic [31:0] base, input bit toggle);
      int sent = 0;
      int cyc  = 0;
      bit rq;
      while (sent < n) begin
         rq = toggle ? (cyc % 2 == 0) : 1'b1;
         bus.ecc_decode_req = rq;
         bus.wr_en          = 1'b1;
         bus.data_in        = rq ? base + 32'(sent) : 32'hDEADBEEF;
         if (rq && sent == CODE_WORDS - 1) chk("rdy_before_last", bus.code_rdy, 1);
         step();
         if (rq) sent++;
         cyc++;
      end
      bus.ecc_decode_req = 1'b0;
      bus.wr_en          = 1'b0;
   endtask

   task automatic give_dec(input logic [31:0] base, input bit fail);
      for (int j = 0; j < DATA_WORDS; j++) bus.dec_data[j*W +: W] = base + 32'(j);
      bus.dec_fail = fail;
      bus.dec_done = 1'b1;
      step();
      bus.dec_done = 1'b0;
      bus.dec_fail = 1'b0;
   endtask

   task automatic read_out(input int n, input logic [31:0] base, input bit toggle,
                           input bit exp_err);
      int j   = 0;
      int cyc = 0;
      bit rd;
      while (j < n) begin
         rd = toggle ? (cyc % 2 == 0) : 1'b1;
         bus.rd_en = rd;
         step();
         if (rd) begin
            chk("out_vld", bus.data_out_vld, 1);
            chk("out_data", bus.data_out, base + 32'(j));
            chk("read_over", bus.read_over, 64'(j == DATA_WORDS - 1));
            chk("dec_err_out", bus.dec_err, exp_err);
            j++;
         end else begin
            chk("idle_vld", bus.data_out_vld, 0);
            chk("hold_data", bus.data_out, base + 32'(j - 1));
            chk("idle_over", bus.read_over, 0);
         end
         cyc++;
      end
      bus.rd_en = 1'b0;
   endtask

   initial begin
      bus.data_in        = '0;
      bus.ecc_decode_req = 1'b0;
      bus.wr_en          = 1'b0;
      bus.dec_done       = 1'b0;
      bus.dec_fail       = 1'b0;
      bus.dec_data       = '0;
      bus.rd_en          = 1'b0;

      #2 rst_n = 1'b0;
      #3;
      chk("rst_code_rdy", bus.code_rdy, 1);
      chk("rst_dec_start", bus.dec_start, 0);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_vld", bus.data_out_vld, 0);
      chk("rst_dec_err", bus.dec_err, 0);
      chk("rst_read_over", bus.read_over, 0);
      chk("rst_cw_lo", bus.codeword[31:0], 0);
      chk("rst_cw_hi", bus.codeword[N-1:N-W], 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // continuous collect and readout
      push(CODE_WORDS, 32'h0, 1'b0);
      chk("t1_cw_lo", bus.codeword[31:0], 0);
      chk("t1_cw_w100", bus.codeword[100*W +: W], 100);
      chk("t1_cw_hi", bus.codeword[N-1:N-W], 287);
      chk("t1_rdy_low", bus.code_rdy, 0);
      chk("t1_start", bus.dec_start, 1);
      step();
      chk("t1_start_end", bus.dec_start, 0);
      chk("t1_ds_cnt", ds_cnt, 1);
      give_dec(32'hA5000000, 1'b0);
      read_out(DATA_WORDS, 32'hA5000000, 1'b0, 1'b0);
      step();
      chk("t1_rdy_back", bus.code_rdy, 1);
      chk("t1_vld_low", bus.data_out_vld, 0);
      chk("t1_over_low", bus.read_over, 0);
      chk("t1_cw_clear", bus.codeword[N-1:N-W], 0);

      // paused collect/readout, decoder failure
      push(CODE_WORDS, 32'h1000, 1'b1);
      chk("t2_cw_lo", bus.codeword[31:0], 32'h1000);
      chk("t2_cw_w1", bus.codeword[63:32], 32'h1001);
      chk("t2_cw_hi", bus.codeword[N-1:N-W], 32'h1000 + 287);
      step();
      chk("t2_ds_cnt", ds_cnt, 2);
      give_dec(32'h5A000000, 1'b1);
      chk("t2_err_set", bus.dec_err, 1);
      read_out(DATA_WORDS, 32'h5A000000, 1'b1, 1'b1);
      step();
      chk("t2_err_hold", bus.dec_err, 1);
      chk("t2_rdy_back", bus.code_rdy, 1);

      // stray dec_done in COLLECT, then 300 words with 12 extras dropped
      bus.dec_data = {K{1'b1}};
      bus.dec_done = 1'b1;
      step();
      bus.dec_done = 1'b0;
      chk("t3_stray_err", bus.dec_err, 1);
      chk("t3_stray_rdy", bus.code_rdy, 1);
      chk("t3_stray_vld", bus.data_out_vld, 0);
      push(300, 32'h2000, 1'b0);
      chk("t3_cw_lo", bus.codeword[31:0], 32'h2000);
      chk("t3_cw_hi", bus.codeword[N-1:N-W], 32'h2000 + 287);
      chk("t3_rdy_low", bus.code_rdy, 0);
      chk("t3_err_clr", bus.dec_err, 0);
      chk("t3_ds_cnt", ds_cnt, 3);
      give_dec(32'h3C000000, 1'b1);
      read_out(100, 32'h3C000000, 1'b0, 1'b1);

      // reset in the middle of readout
      rst_n = 1'b0;
      #1;
      chk("t4_rst_vld", bus.data_out_vld, 0);
      chk("t4_rst_data", bus.data_out, 0);
      chk("t4_rst_over", bus.read_over, 0);
      chk("t4_rst_rdy", bus.code_rdy, 1);
      chk("t4_rst_err", bus.dec_err, 0);
      chk("t4_rst_cw", bus.codeword[31:0], 0);
      bus.rd_en = 1'b1;
      step();
      chk("t4_rst_no_out", bus.data_out_vld, 0);
      bus.rd_en = 1'b0;
      rst_n = 1'b1;
      step();

      push(CODE_WORDS, 32'h4000, 1'b0);
      chk("t4_cw_lo", bus.codeword[31:0], 32'h4000);
      chk("t4_cw_hi", bus.codeword[N-1:N-W], 32'h4000 + 287);
      step();
      chk("t4_ds_cnt", ds_cnt, 4);
      give_dec(32'h7E000000, 1'b0);
      read_out(DATA_WORDS, 32'h7E000000, 1'b0, 1'b0);
      step();
      chk("t4_rdy_back", bus.code_rdy, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
